synth_ctrl_scheduler: RTL
=========================

// Module: synth_ctrl_scheduler
// PURPOSE
//  Control front-end for the 10-voice wavetable synthesizer. Generates the 64x-sample-rate tick strobe
//  and the synth enable, and sequences clean start/stop on frame boundaries.
//  Round-robin arbitrates two command sources (MIDI parser, panel buttons) into shadow registers.
//  Commits key/pitch/volume/modulation to the synth only at frame end, so one output frame never mixes old and new settings.
// PARAMETERS
//  CLK_DIV    32     clk cycles per tick (>=4); 100 MHz/32/64 = 48.8 kHz sample rate
//  PITCH_MAX  19     highest legal pitchshift index
//  RST_PITCH  7      pitchshift after reset (no transposition)
//  RST_VOL    8'h80  volume after reset
// PORTS
//  clk            in   1   system clock (100 MHz)
//  rst            in   1   asynchronous reset, active high
//  run            in   1   level: 1 = synth should play
//  s0_valid       in   1   requester 0 (MIDI) command valid
//  s0_cmd         in   3   requester 0 opcode
//  s0_arg         in   8   requester 0 argument
//  s0_ready       out  1   requester 0 command accepted this cycle (combinational grant)
//  s1_valid/s1_cmd/s1_arg/s1_ready     as s0, requester 1 (panel)
//  err_clr        in   1   clears cmd_err
//  tick           out  1   one-cycle strobe, drives synth ena_sampleRatex64
//  synth_ena      out  1   drives synth ena
//  key_out        out  10  committed key mask
//  pitchshift_out out  5   committed pitchshift
//  volume_out     out  8   committed volume
//  modulation_out out  8   committed modulation
//  frame_sync     out  1   one-cycle pulse on each commit
//  cmd_err        out  1   sticky illegal-command flag
// BEHAVIOUR
//  Reset: state IDLE; tick=0, synth_ena=0, frame_sync=0, cmd_err=0; key_out=0, pitchshift_out=RST_PITCH,
//   volume_out=RST_VOL, modulation_out=0; shadows equal these; div_cnt=0, tick_cnt=63, last_grant=1.
//   Reset is asynchronous and aborts any state immediately.
//  Opcodes (one command per cycle max):
//   0 NOTE_ON  key[arg[3:0]]=1     1 NOTE_OFF key[arg[3:0]]=0    2 SET_PITCH arg[4:0]
//   3 SET_VOL arg                  4 SET_MOD arg                 5 ALL_OFF  keys=0
//   6,7 reserved: accepted, no effect, cmd_err=1.
//   Key index >9: accepted, no effect, cmd_err=1.
//   Pitch >PITCH_MAX: clamped to PITCH_MAX, cmd_err=1.
//  Arbitration (every state, including IDLE): sx_ready = grant. A single valid requester is granted the same cycle.
//   If both are valid, grant !last_grant; s0 wins the first tie after reset. last_grant updates on every grant.
//   A requester holding valid is never starved by more than one cycle.
//   The accepted command updates the shadows on the next clk edge; conflicting commands from both sides are serialised, last wins.
//  cmd_err: set on an illegal accept; cleared by err_clr; a set in the same cycle as err_clr wins.
//  Tick: div_cnt counts 0..CLK_DIV-1 in RUN/DRAIN/STOP; tick=1 when div_cnt==CLK_DIV-1. div_cnt is held 0 in IDLE.
//   tick_cnt increments on each tick, wrapping 63->0, in phase with the synth's internal cnt.
//  Commit: on tick with tick_cnt==63, copy shadows to outputs and pulse frame_sync. In IDLE, outputs follow shadows 1 cycle later.
//  FSM:
//   IDLE  -> RUN   when run=1: synth_ena<=1, tick_cnt<=63; first tick comes CLK_DIV cycles later and commits.
//   RUN   -> DRAIN when run=0.
//   DRAIN -> RUN   when run=1 again; synth_ena stays 1.
//   DRAIN -> STOP  on the commit tick: synth_ena<=0.
//   STOP: emits exactly one more tick (synth samples ~ena), then -> IDLE. run is ignored in STOP.
// TESTING
//  Reset pulse mid-RUN -> same cycle: synth_ena=0, tick=0, key_out=0, pitchshift_out=7, volume_out=8'h80.
//  run=1 at cycle 0 -> synth_ena=1 at cycle 1; tick at cycles 32,64,...; frame_sync at 32, 2080, 4128.
//  Same cycle: s0 NOTE_ON 3 and s1 NOTE_ON 5 -> s0_ready that cycle, s1_ready next; key_out stays 0 until commit tick, then 10'h028.
//  SET_PITCH arg=25 -> pitchshift_out=19 at next commit, cmd_err=1; err_clr -> cmd_err=0; reserved op 6 -> cmd_err=1, outputs unchanged.
//  run=0 at tick_cnt=10 -> ticks continue to commit tick, synth_ena falls, one more tick after 32 cycles, then no ticks (IDLE).
//  run toggles 1->0->1 inside one frame -> synth_ena never drops; tick spacing unchanged.

Source files
------------

// File: rtl/synth_ctrl_scheduler_if.sv
// Command request bundle from the two scheduler requesters (MIDI parser = s0, panel = s1).
interface synth_ctrl_scheduler_if;
  logic       s0_valid;
  logic [2:0] s0_cmd;
  logic [7:0] s0_arg;
  logic       s0_ready;
  logic       s1_valid;
  logic [2:0] s1_cmd;
  logic [7:0] s1_arg;
  logic       s1_ready;

  modport master (
    output s0_valid, s0_cmd, s0_arg,
    input  s0_ready,
    output s1_valid, s1_cmd, s1_arg,
    input  s1_ready
  );

  modport slave (
    input  s0_valid, s0_cmd, s0_arg,
    output s0_ready,
    input  s1_valid, s1_cmd, s1_arg,
    output s1_ready
  );
endinterface

// File: rtl/synth_ctrl_scheduler.sv
// Wavetable synth control front-end: tick generation, run/stop sequencing on frame
// boundaries, round-robin command arbitration into shadows, frame-aligned commit.
module synth_ctrl_scheduler #(
  parameter int unsigned CLK_DIV   = 32,
  parameter int unsigned PITCH_MAX = 19,
  parameter logic [4:0]  RST_PITCH = 5'd7,
  parameter logic [7:0]  RST_VOL   = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  synth_ctrl_scheduler_if.slave req,
  input  logic                  err_clr,
  output logic                  tick,
  output logic                  synth_ena,
  output logic [9:0]            key_out,
  output logic [4:0]            pitchshift_out,
  output logic [7:0]            volume_out,
  output logic [7:0]            modulation_out,
  output logic                  frame_sync,
  output logic                  cmd_err
);
  localparam int unsigned       DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]        PITCH_LIM = 5'(PITCH_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_STOP} state_e;
  typedef enum logic [2:0] {
    OP_NOTE_ON   = 3'd0,
    OP_NOTE_OFF  = 3'd1,
    OP_SET_PITCH = 3'd2,
    OP_SET_VOL   = 3'd3,
    OP_SET_MOD   = 3'd4,
    OP_ALL_OFF   = 3'd5
  } op_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]       tick_cnt_q, tick_cnt_d;
  logic             synth_ena_q, synth_ena_d;
  logic             last_grant_q, last_grant_d;
  logic             cmd_err_q, cmd_err_d;
  logic [9:0]       sh_key_q, sh_key_d;
  logic [4:0]       sh_pitch_q, sh_pitch_d;
  logic [7:0]       sh_vol_q, sh_vol_d;
  logic [7:0]       sh_mod_q, sh_mod_d;
  logic [9:0]       key_q, key_d;
  logic [4:0]       pitch_q, pitch_d;
  logic [7:0]       vol_q, vol_d;
  logic [7:0]       mod_q, mod_d;

  logic       gnt0, gnt1, acc, illegal;
  logic [2:0] sel_cmd;
  logic [7:0] sel_arg;
  logic       tick_int, commit, start, halt, follow;

  // Round-robin: a lone requester wins immediately, a tie goes to whoever lost last.
  always_comb begin
    gnt0         = req.s0_valid && (!req.s1_valid || last_grant_q);
    gnt1         = req.s1_valid && (!req.s0_valid || !last_grant_q);
    req.s0_ready = gnt0;
    req.s1_ready = gnt1;
    acc          = gnt0 || gnt1;
    sel_cmd      = gnt0 ? req.s0_cmd : req.s1_cmd;
    sel_arg      = gnt0 ? req.s0_arg : req.s1_arg;
    last_grant_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_grant_q);
  end

  always_comb begin
    sh_key_d   = sh_key_q;
    sh_pitch_d = sh_pitch_q;
    sh_vol_d   = sh_vol_q;
    sh_mod_d   = sh_mod_q;
    illegal    = 1'b0;
    if (acc) begin
      case (op_e'(sel_cmd))
        OP_NOTE_ON: begin
          if (sel_arg[3:0] > 4'd9) illegal = 1'b1;
          else                     sh_key_d[sel_arg[3:0]] = 1'b1;
        end
        OP_NOTE_OFF: begin
          if (sel_arg[3:0] > 4'd9) illegal = 1'b1;
          else                     sh_key_d[sel_arg[3:0]] = 1'b0;
        end
        OP_SET_PITCH: begin
          if (sel_arg[4:0] > PITCH_LIM) begin
            sh_pitch_d = PITCH_LIM;
            illegal    = 1'b1;
          end else begin
            sh_pitch_d = sel_arg[4:0];
          end
        end
        OP_SET_VOL: sh_vol_d = sel_arg;
        OP_SET_MOD: sh_mod_d = sel_arg;
        OP_ALL_OFF: sh_key_d = '0;
        default:    illegal  = 1'b1;
      endcase
    end
    // A new error outranks a simultaneous clear.
    cmd_err_d = illegal ? 1'b1 : (err_clr ? 1'b0 : cmd_err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_RUN;
      S_RUN:   if (!run) state_d = S_DRAIN;
      S_DRAIN: begin
        if (run)         state_d = S_RUN;
        else if (commit) state_d = S_STOP;
      end
      S_STOP:  if (tick_int) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_int   = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);
    commit     = tick_int && (tick_cnt_q == '1);
    start      = (state_q == S_IDLE) && run;
    halt       = (state_q == S_DRAIN) && !run && commit;
    follow     = (state_q == S_IDLE);
    tick       = tick_int;
    frame_sync = commit;
  end

  // tick_cnt is preloaded to 63 on start so the very first tick is a commit tick.
  always_comb begin
    div_cnt_d   = (follow || tick_int) ? '0 : div_cnt_q + 1'b1;
    tick_cnt_d  = start ? '1 : (tick_int ? tick_cnt_q + 1'b1 : tick_cnt_q);
    synth_ena_d = start ? 1'b1 : (halt ? 1'b0 : synth_ena_q);
    key_d       = key_q;
    pitch_d     = pitch_q;
    vol_d       = vol_q;
    mod_d       = mod_q;
    if (follow || commit) begin
      key_d   = sh_key_q;
      pitch_d = sh_pitch_q;
      vol_d   = sh_vol_q;
      mod_d   = sh_mod_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      tick_cnt_q   <= '1;
      synth_ena_q  <= 1'b0;
      last_grant_q <= 1'b1;
      cmd_err_q    <= 1'b0;
      sh_key_q     <= '0;
      sh_pitch_q   <= RST_PITCH;
      sh_vol_q     <= RST_VOL;
      sh_mod_q     <= '0;
      key_q        <= '0;
      pitch_q      <= RST_PITCH;
      vol_q        <= RST_VOL;
      mod_q        <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      synth_ena_q  <= synth_ena_d;
      last_grant_q <= last_grant_d;
      cmd_err_q    <= cmd_err_d;
      sh_key_q     <= sh_key_d;
      sh_pitch_q   <= sh_pitch_d;
      sh_vol_q     <= sh_vol_d;
      sh_mod_q     <= sh_mod_d;
      key_q        <= key_d;
      pitch_q      <= pitch_d;
      vol_q        <= vol_d;
      mod_q        <= mod_d;
    end
  end

  assign synth_ena      = synth_ena_q;
  assign cmd_err        = cmd_err_q;
  assign key_out        = key_q;
  assign pitchshift_out = pitch_q;
  assign volume_out     = vol_q;
  assign modulation_out = mod_q;
endmodule
